// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared op codes, state encoding and constants for the QBUS master
package qbus_pkg;

    // Command op codes as presented on cmd_op
    typedef enum logic [1:0] {
        QOP_READ   = 2'b00,
        QOP_WRITE  = 2'b01,
        QOP_WRBYTE = 2'b10,
        QOP_INTA   = 2'b11
    } qop_t;

    // Bus cycle sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SYNC,
        ST_DATA,
        ST_WAIT,
        ST_END,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    // Flop stages on each asynchronous bus input
    localparam int SYNC_DEPTH = 2;

    function automatic logic is_write(qop_t op);
        return (op == QOP_WRITE) || (op == QOP_WRBYTE);
    endfunction

endpackage

// File: rtl/qbus_sync2.sv
// rtl/qbus_sync2.sv - two-flop synchronizer for asynchronous QBUS inputs
//
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, loads RST_VAL into every stage
//   d     - asynchronous input
//   q     - synchronized output
module qbus_sync2
    import qbus_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            sr <= {sr[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sr[SYNC_DEPTH-1];

endmodule

// File: rtl/qbus_master.sv
// rtl/qbus_master.sv - QBUS master sequencer for read, write, byte write and INTA cycles
//
// Ports:
//   clk, reset              - system clock, synchronous active-high reset
//   cmd_req/cmd_ack         - command handshake, ack pulses for one cycle on acceptance
//   cmd_op/addr/data        - op code, address and write data (true polarity)
//   resp_valid/data/err     - completion pulse, read/vector data, RPLY timeout flag
//   ad_in/ad_out/ad_oe      - nAD bus sample, drive value and output enable (active-low data)
//   sync_n..iako_n          - QBUS strobes, active-low
//   rply_n, init_n          - asynchronous QBUS inputs, active-low
module qbus_master
    import qbus_pkg::*;
#(
    parameter int ADDR_CYC = 2,
    parameter int SYNC_CYC = 1,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    input  logic [15:0] ad_in,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    output logic        bsy_n,
    output logic        iako_n,
    input  logic        rply_n,
    input  logic        init_n
);

    // One counter times the address/sync phases and the RPLY waits, so it
    // must be wide enough for the largest of the three.
    localparam int CMAX_AS = (ADDR_CYC > SYNC_CYC) ? ADDR_CYC : SYNC_CYC;
    localparam int CMAX    = (TIMEOUT > CMAX_AS) ? TIMEOUT : CMAX_AS;
    localparam int CW      = $clog2(CMAX + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_CYC - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CMAX);

    state_t        state, state_nx;
    qop_t          op_q;
    logic [15:0]   addr_q;
    logic [15:0]   data_q;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          rply_s;
    logic          init_s;
    logic          accept;
    logic          tmo;

    qbus_sync2 #(.RST_VAL(1'b1)) u_sync_rply (
        .clk   (clk),
        .reset (reset),
        .d     (rply_n),
        .q     (rply_s)
    );

    qbus_sync2 #(.RST_VAL(1'b1)) u_sync_init (
        .clk   (clk),
        .reset (reset),
        .d     (init_n),
        .q     (init_s)
    );

    assign accept  = (state == ST_IDLE) && cmd_req && init_s && !reset;
    assign cmd_ack = accept;
    // Counter holds the number of cycles already spent in the current state
    assign tmo     = (cnt == TMO_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (accept) state_nx = ST_ADDR;
            ST_ADDR:    if (cnt == ADDR_LAST) state_nx = ST_SYNC;
            ST_SYNC:    if (cnt == SYNC_LAST) state_nx = ST_DATA;
            ST_DATA:    state_nx = ST_WAIT;
            // A reply seen in the same cycle as expiry is still a good reply
            ST_WAIT:    if (!rply_s || tmo) state_nx = ST_END;
            ST_END: begin
                if (rply_s)   state_nx = ST_HOLD;
                else if (tmo) state_nx = ST_RELEASE;
            end
            ST_HOLD:    state_nx = ST_RELEASE;
            ST_RELEASE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (state != ST_IDLE && !init_s) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= QOP_READ;
            addr_q    <= 16'h0000;
            data_q    <= 16'h0000;
            cnt       <= '0;
            err_q     <= 1'b0;
            resp_data <= 16'h0000;
        end else begin
            state <= state_nx;
            if (state_nx != state)   cnt <= '0;
            else if (cnt != CNT_SAT) cnt <= cnt + CW'(1);

            if (accept) begin
                op_q   <= qop_t'(cmd_op);
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                err_q  <= 1'b0;
            end

            if (state == ST_WAIT && init_s) begin
                if (!rply_s) begin
                    if (!is_write(op_q)) resp_data <= ~ad_in;
                end else if (tmo) begin
                    err_q     <= 1'b1;
                    resp_data <= 16'h0000;
                end
            end

            // RPLY stuck low after the data strobe went away
            if (state == ST_END && init_s && !rply_s && tmo) err_q <= 1'b1;
        end
    end

    always_comb begin
        sync_n     = 1'b1;
        din_n      = 1'b1;
        dout_n     = 1'b1;
        wtbt_n     = 1'b1;
        bsy_n      = 1'b1;
        iako_n     = 1'b1;
        ad_oe      = 1'b0;
        ad_out     = 16'hFFFF;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_ADDR, ST_SYNC: begin
                bsy_n  = 1'b0;
                wtbt_n = !is_write(op_q);
                if (op_q != QOP_INTA) begin
                    ad_oe  = 1'b1;
                    ad_out = ~addr_q;
                end
                if (state == ST_SYNC) sync_n = 1'b0;
            end
            ST_DATA, ST_WAIT, ST_END, ST_HOLD: begin
                // Data strobes drop in END; bus ownership and write data stay
                // until RELEASE so the slave never sees the lines float early.
                logic strobe;
                strobe = (state == ST_DATA) || (state == ST_WAIT);
                bsy_n  = 1'b0;
                sync_n = !strobe;
                case (op_q)
                    QOP_WRITE, QOP_WRBYTE: begin
                        ad_oe  = 1'b1;
                        ad_out = ~data_q;
                        dout_n = !strobe;
                        wtbt_n = (op_q == QOP_WRITE);
                    end
                    QOP_INTA: begin
                        iako_n = !strobe;
                        din_n  = !strobe;
                    end
                    default: begin
                        din_n = !strobe;
                    end
                endcase
            end
            ST_RELEASE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qbus_master.sv
// tb/tb_qbus_master.sv - directed self-checking bench for qbus_master
module tb_qbus_master;
    import qbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_req = 1'b0;
    logic        cmd_ack;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0000;
    logic [15:0] cmd_data = 16'h0000;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic        sync_n, din_n, dout_n, wtbt_n, bsy_n, iako_n;
    logic        rply_n = 1'b1;
    logic        init_n = 1'b1;

    // Slave model controls and state
    logic        slave_en = 1'b0;
    logic        slave_stuck = 1'b0;
    logic [15:0] slave_rdata = 16'h0000;
    logic [15:0] slave_ad = 16'hFFFF;
    logic [15:0] slave_seen = 16'h0000;
    int          scnt = 0;

    // Per-transaction observations
    int          lat;
    logic        got_valid, got_sync, saw_din, saw_oe, saw_iako_din;
    logic        r_err, rel_bsy, addr_wtbt, dout_wtbt;
    logic [15:0] r_data, sync_addr, dout_val;

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    assign ad_in = ad_oe ? ad_out : slave_ad;

    qbus_master #(.ADDR_CYC(2), .SYNC_CYC(1), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_req    (cmd_req),
        .cmd_ack    (cmd_ack),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .ad_in      (ad_in),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .sync_n     (sync_n),
        .din_n      (din_n),
        .dout_n     (dout_n),
        .wtbt_n     (wtbt_n),
        .bsy_n      (bsy_n),
        .iako_n     (iako_n),
        .rply_n     (rply_n),
        .init_n     (init_n)
    );

    // Slave: replies on the third falling edge that sees DIN or DOUT low,
    // releases RPLY once the strobe is gone (unless told to stick).
    always @(negedge clk) begin
        if (!slave_en) begin
            rply_n   = 1'b1;
            slave_ad = 16'hFFFF;
            scnt     = 0;
        end else if (!din_n || !dout_n) begin
            if (scnt < 3) scnt = scnt + 1;
            if (scnt == 3) begin
                rply_n = 1'b0;
                if (!din_n) slave_ad = ~slave_rdata;
                else        slave_seen = ad_out;
            end
        end else if (!slave_stuck) begin
            rply_n   = 1'b1;
            slave_ad = 16'hFFFF;
            scnt     = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] data);
        got_valid = 0; got_sync = 0; saw_din = 0; saw_oe = 0; saw_iako_din = 0;
        r_err = 0; rel_bsy = 0; addr_wtbt = 1; dout_wtbt = 0;
        r_data = 0; sync_addr = 0; dout_val = 0;
        @(negedge clk);
        cmd_req = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        #1;
        chk({tag, "_ack"}, {31'd0, cmd_ack}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_req = 1'b0;
        lat = 1;
        while (lat <= 60) begin
            if (lat == 1) addr_wtbt = wtbt_n;
            if (!sync_n && !got_sync) begin
                got_sync  = 1;
                sync_addr = ad_out;
            end
            if (!din_n) saw_din = 1;
            if (!dout_n) begin
                dout_val  = ad_out;
                dout_wtbt = wtbt_n;
            end
            if (ad_oe) saw_oe = 1;
            if (!iako_n && !din_n) saw_iako_din = 1;
            if (resp_valid) begin
                got_valid = 1;
                r_err     = resp_err;
                r_data    = resp_data;
                rel_bsy   = bsy_n;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, got_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic saw_v;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {26'd0, sync_n, din_n, dout_n, wtbt_n, bsy_n, iako_n}, 32'h3F);
        chk("rst_ad", {15'd0, ad_oe, ad_out}, 32'h0000FFFF);
        chk("rst_resp", {13'd0, cmd_ack, resp_valid, resp_err, resp_data}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Read 177716, slave returns 000200
        slave_en = 1'b1; slave_rdata = 16'o000200;
        do_cmd("rd", QOP_READ, 16'o177716, 16'h0000);
        chk("rd_sync_addr", {16'd0, sync_addr}, {16'd0, ~16'o177716});
        chk("rd_din", {31'd0, saw_din}, 32'd1);
        chk("rd_data", {16'd0, r_data}, {16'd0, 16'o000200});
        chk("rd_err", {31'd0, r_err}, 32'd0);
        chk("rd_lat", lat, 32'd13);
        @(negedge clk);
        chk("rd_after", {30'd0, resp_valid, bsy_n}, 32'd1);

        // Word write 177564 <- 000101
        do_cmd("wr", QOP_WRITE, 16'o177564, 16'o000101);
        chk("wr_wtbt_addr", {31'd0, addr_wtbt}, 32'd0);
        chk("wr_wtbt_data", {31'd0, dout_wtbt}, 32'd1);
        chk("wr_dout_val", {16'd0, dout_val}, {16'd0, ~16'o000101});
        chk("wr_err", {31'd0, r_err}, 32'd0);
        chk("wr_data_kept", {16'd0, r_data}, {16'd0, 16'o000200});

        // Byte write 177566 <- 000123
        do_cmd("wb", QOP_WRBYTE, 16'o177566, 16'o000123);
        chk("wb_wtbt_addr", {31'd0, addr_wtbt}, 32'd0);
        chk("wb_wtbt_data", {31'd0, dout_wtbt}, 32'd0);
        chk("wb_slave_seen", {16'd0, slave_seen}, {16'd0, ~16'o000123});

        // Interrupt acknowledge, vector 000060
        slave_rdata = 16'o000060;
        do_cmd("ia", QOP_INTA, 16'o000000, 16'h0000);
        chk("ia_oe", {31'd0, saw_oe}, 32'd0);
        chk("ia_iako_din", {31'd0, saw_iako_din}, 32'd1);
        chk("ia_data", {16'd0, r_data}, {16'd0, 16'o000060});

        // No reply: 16 WAIT cycles, then END, HOLD, RELEASE
        slave_en = 1'b0;
        do_cmd("to", QOP_READ, 16'o177700, 16'h0000);
        chk("to_err", {31'd0, r_err}, 32'd1);
        chk("to_data", {16'd0, r_data}, 32'd0);
        chk("to_lat", lat, 32'd23);
        chk("to_rel_bsy", {31'd0, rel_bsy}, 32'd1);
        @(negedge clk);
        chk("to_after", {25'd0, resp_valid, sync_n, din_n, dout_n, wtbt_n, bsy_n, iako_n}, 32'h3F);

        // RPLY stuck low after the strobe: END times out with error
        slave_en = 1'b1; slave_stuck = 1'b1; slave_rdata = 16'o000777;
        do_cmd("st", QOP_READ, 16'o177710, 16'h0000);
        chk("st_err", {31'd0, r_err}, 32'd1);
        chk("st_data", {16'd0, r_data}, {16'd0, 16'o000777});
        chk("st_lat", lat, 32'd25);
        slave_stuck = 1'b0;
        repeat (4) @(negedge clk);

        // INIT asserted during WAIT_RPLY aborts the cycle
        slave_en = 1'b0;
        @(negedge clk);
        cmd_req = 1'b1; cmd_op = QOP_READ; cmd_addr = 16'o177702;
        @(posedge clk);
        @(negedge clk);
        cmd_req = 1'b0;
        repeat (6) @(negedge clk);
        init_n = 1'b0;
        saw_v = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_v = 1'b1;
        end
        chk("init_no_valid", {31'd0, saw_v}, 32'd0);
        chk("init_strobes", {26'd0, sync_n, din_n, dout_n, wtbt_n, bsy_n, iako_n}, 32'h3F);
        chk("init_ad", {15'd0, ad_oe, ad_out}, 32'h0000FFFF);
        cmd_req = 1'b1;
        #1;
        chk("init_no_ack", {31'd0, cmd_ack}, 32'd0);
        @(negedge clk);
        cmd_req = 1'b0;
        init_n  = 1'b1;
        repeat (3) @(negedge clk);

        // Normal read after the abort
        slave_en = 1'b1; slave_rdata = 16'o001234;
        do_cmd("pi", QOP_READ, 16'o177704, 16'h0000);
        chk("pi_data", {16'd0, r_data}, {16'd0, 16'o001234});
        chk("pi_err", {31'd0, r_err}, 32'd0);
        chk("pi_lat", lat, 32'd13);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
